// File: rtl/sdr_pkg.sv
// Shared SDR definitions: FTDI header layout, source codes, arbiter state encoding
// and the receive-side header decoder used by the host link.
package sdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR      = 2'd1,
        IQ_DATA  = 2'd2,
        CPU_DATA = 2'd3
    } a2f_state_t;

    typedef enum logic {
        TOFIFO = 1'b0,
        TOCPU  = 1'b1
    } src_t;

    localparam int HDR_SRC_BIT     = 31;
    localparam int HDR_CPU_LEN_LSB = 20;
    localparam int HDR_CPU_LEN_W   = 8;
    localparam int HDR_IQ_LEN_LSB  = 0;
    localparam int HDR_IQ_LEN_W    = 16;

    typedef struct packed {
        src_t        src;
        logic [15:0] len;
    } hdr_t;

    // Receive side: recover source and data-word count from a header word.
    function automatic hdr_t decode_hdr(input logic [31:0] word);
        hdr_t h;
        h.src = src_t'(word[HDR_SRC_BIT]);
        if (h.src == TOCPU)
            h.len = {8'd0, word[HDR_CPU_LEN_LSB +: HDR_CPU_LEN_W]};
        else
            h.len = word[HDR_IQ_LEN_LSB +: HDR_IQ_LEN_W];
        return h;
    endfunction

endpackage

// File: rtl/a2f_fmt.sv
// Combinational formatter for FTDI header words and packed I/Q data words.
module a2f_fmt
    import sdr_pkg::*;
#(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16
) (
    input  src_t                     src,
    input  logic [15:0]              len,
    input  logic [IQ_PAIR_WIDTH-1:0] iq_pair,
    output logic [FT_DATA_WIDTH-1:0] hdr_word,
    output logic [FT_DATA_WIDTH-1:0] iq_word
);

    localparam int HALF = IQ_PAIR_WIDTH / 2;

    always_comb begin
        hdr_word = '0;
        if (src == TOCPU) begin
            hdr_word[HDR_SRC_BIT] = 1'b1;
            hdr_word[HDR_CPU_LEN_LSB +: HDR_CPU_LEN_W] = len[HDR_CPU_LEN_W-1:0];
        end else begin
            hdr_word[HDR_IQ_LEN_LSB +: HDR_IQ_LEN_W] = len;
        end
    end

    // Q moves up to its own lane; I stays at the bottom, gaps are zero.
    always_comb begin
        iq_word = '0;
        iq_word[QSTART_BIT_INDEX +: HALF] = iq_pair[HALF +: HALF];
        iq_word[0 +: HALF]                = iq_pair[0 +: HALF];
    end

endmodule

// File: rtl/arb_a2f.sv
// Round-robin arbiter merging IQ samples and CPU responses into headered
// packets on the FTDI transmit path.
module arb_a2f
    import sdr_pkg::*;
#(
    parameter int          FT_DATA_WIDTH    = 32,
    parameter int          IQ_PAIR_WIDTH    = 24,
    parameter int          QSTART_BIT_INDEX = 16,
    parameter logic [15:0] IQ_BURST         = 16'd256
) (
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
    input  logic                     fifo_empty_i,
    input  logic                     fifo_enough_i,
    output logic                     fifo_re_o,
    input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
    input  logic                     cpu_empty_i,
    input  logic                     cpu_req_i,
    input  logic [7:0]               cpu_len_i,
    output logic                     cpu_re_o,
    output logic                     cpu_grant_o,
    input  logic                     full_i,
    output logic [FT_DATA_WIDTH-1:0] data_o,
    output logic                     we_o,
    output logic                     busy_o
);

    a2f_state_t  state;
    src_t        src;
    src_t        last_grant;
    src_t        grant_src;
    logic [15:0] len;
    logic [15:0] count;
    logic [15:0] grant_len;
    logic        grant_any;
    logic [FT_DATA_WIDTH-1:0] hdr_word;
    logic [FT_DATA_WIDTH-1:0] iq_word;

    a2f_fmt #(
        .FT_DATA_WIDTH   (FT_DATA_WIDTH),
        .IQ_PAIR_WIDTH   (IQ_PAIR_WIDTH),
        .QSTART_BIT_INDEX(QSTART_BIT_INDEX)
    ) u_fmt (
        .src     (src),
        .len     (len),
        .iq_pair (fifo_data_i),
        .hdr_word(hdr_word),
        .iq_word (iq_word)
    );

    // CPU wins only when IQ is absent or IQ had the previous grant.
    assign grant_any = fifo_enough_i | cpu_req_i;
    assign grant_src = (cpu_req_i && (!fifo_enough_i || last_grant == TOFIFO)) ? TOCPU : TOFIFO;
    assign grant_len = (grant_src == TOCPU) ? {8'd0, cpu_len_i} : IQ_BURST;

    assign fifo_re_o = (state == IQ_DATA)  && !full_i && !fifo_empty_i;
    assign cpu_re_o  = (state == CPU_DATA) && !full_i && !cpu_empty_i;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            src         <= TOFIFO;
            last_grant  <= TOCPU;
            len         <= '0;
            count       <= '0;
            data_o      <= '0;
            we_o        <= 1'b0;
            cpu_grant_o <= 1'b0;
        end else begin
            we_o        <= 1'b0;
            cpu_grant_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        src         <= grant_src;
                        last_grant  <= grant_src;
                        len         <= grant_len;
                        count       <= '0;
                        cpu_grant_o <= (grant_src == TOCPU);
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (!full_i) begin
                        data_o <= hdr_word;
                        we_o   <= 1'b1;
                        if (len == 16'd0)
                            state <= IDLE;
                        else
                            state <= (src == TOCPU) ? CPU_DATA : IQ_DATA;
                    end
                end
                IQ_DATA: begin
                    if (fifo_re_o) begin
                        data_o <= iq_word;
                        we_o   <= 1'b1;
                        count  <= count + 16'd1;
                        if (count == len - 16'd1)
                            state <= IDLE;
                    end
                end
                CPU_DATA: begin
                    if (cpu_re_o) begin
                        data_o <= cpu_data_i;
                        we_o   <= 1'b1;
                        count  <= count + 16'd1;
                        if (count == len - 16'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_a2f.sv
// Directed bench for arb_a2f with IQ_BURST=4 and queue-backed FWFT source FIFOs.
module tb_arb_a2f;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic [23:0] fifo_data_i;
    logic        fifo_empty_i;
    logic        fifo_enough_i;
    logic        fifo_re_o;
    logic [31:0] cpu_data_i;
    logic        cpu_empty_i;
    logic        cpu_req_i;
    logic [7:0]  cpu_len_i;
    logic        cpu_re_o;
    logic        cpu_grant_o;
    logic        full_i;
    logic [31:0] data_o;
    logic        we_o;
    logic        busy_o;

    logic [23:0] iq_q[$];
    logic [31:0] cpu_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    arb_a2f #(
        .FT_DATA_WIDTH   (32),
        .IQ_PAIR_WIDTH   (24),
        .QSTART_BIT_INDEX(16),
        .IQ_BURST        (16'd4)
    ) dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_enough_i(fifo_enough_i),
        .fifo_re_o    (fifo_re_o),
        .cpu_data_i   (cpu_data_i),
        .cpu_empty_i  (cpu_empty_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_len_i    (cpu_len_i),
        .cpu_re_o     (cpu_re_o),
        .cpu_grant_o  (cpu_grant_o),
        .full_i       (full_i),
        .data_o       (data_o),
        .we_o         (we_o),
        .busy_o       (busy_o)
    );

    task automatic syncFifos();
        fifo_empty_i = (iq_q.size() == 0);
        fifo_data_i  = (iq_q.size() != 0) ? iq_q[0] : 24'd0;
        cpu_empty_i  = (cpu_q.size() == 0);
        cpu_data_i   = (cpu_q.size() != 0) ? cpu_q[0] : 32'd0;
    endtask

    // One clock: pops follow the strobes seen at the edge, then park on the falling edge.
    task automatic tick();
        logic iq_pop;
        logic cpu_pop;
        @(posedge clk_i);
        iq_pop  = fifo_re_o;
        cpu_pop = cpu_re_o;
        #1;
        if (iq_pop && iq_q.size() != 0) void'(iq_q.pop_front());
        if (cpu_pop && cpu_q.size() != 0) void'(cpu_q.pop_front());
        syncFifos();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic enough, input logic req, input logic [7:0] len, input logic full);
        fifo_enough_i = enough;
        cpu_req_i     = req;
        cpu_len_i     = len;
        full_i        = full;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expectWrite(input string tag, input logic [31:0] word);
        checkOutput({tag, "_we"}, {31'd0, we_o}, 32'd1);
        checkOutput(tag, data_o, word);
    endtask

    task automatic expectNoWrite(input string tag);
        checkOutput({tag, "_we"}, {31'd0, we_o}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'd1, 1'b0);
        for (int k = 1; k <= 8; k++) iq_q.push_back({12'(k), 12'(k)});
        cpu_q.push_back(32'h11111111);
        syncFifos();
        @(negedge clk_i);
        @(negedge clk_i);

        $display("[TB] reset state");
        checkOutput("rst_data", data_o, 32'd0);
        expectNoWrite("rst");
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_grant", {31'd0, cpu_grant_o}, 32'd0);
        checkOutput("rst_re", {30'd0, fifo_re_o, cpu_re_o}, 32'd0);

        $display("[TB] tie at reset exit: IQ, CPU, IQ");
        reset_n = 1'b1;
        tick();
        checkOutput("tie1_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("tie1_grant", {31'd0, cpu_grant_o}, 32'd0);
        expectNoWrite("tie1_grantcyc");
        tick();
        expectWrite("tie1_hdr", 32'h00000004);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expectWrite($sformatf("tie1_w%0d", k), 32'h00010001 * k);
        end
        checkOutput("tie1_done_busy", {31'd0, busy_o}, 32'd0);
        tick();
        checkOutput("tie2_grant", {31'd0, cpu_grant_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0);
        tick();
        expectWrite("tie2_hdr", 32'h80100000);
        checkOutput("tie2_grant_off", {31'd0, cpu_grant_o}, 32'd0);
        tick();
        expectWrite("tie2_w", 32'h11111111);
        checkOutput("tie2_done_busy", {31'd0, busy_o}, 32'd0);
        tick();
        checkOutput("tie3_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("tie3_grant", {31'd0, cpu_grant_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("tie3_hdr", 32'h00000004);
        for (int k = 5; k <= 8; k++) begin
            tick();
            expectWrite($sformatf("tie3_w%0d", k), 32'h00010001 * k);
        end
        checkOutput("tie3_done_busy", {31'd0, busy_o}, 32'd0);

        $display("[TB] CPU len 2 with underrun");
        cpu_q.push_back(32'hDEADBEEF);
        syncFifos();
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0);
        tick();
        checkOutput("cpu_grant", {31'd0, cpu_grant_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("cpu_hdr", 32'h80200000);
        tick();
        expectWrite("cpu_w0", 32'hDEADBEEF);
        checkOutput("cpu_underrun_re", {31'd0, cpu_re_o}, 32'd0);
        tick();
        expectNoWrite("cpu_stall");
        checkOutput("cpu_stall_busy", {31'd0, busy_o}, 32'd1);
        cpu_q.push_back(32'h12345678);
        syncFifos();
        tick();
        expectWrite("cpu_w1", 32'h12345678);
        checkOutput("cpu_done_busy", {31'd0, busy_o}, 32'd0);
        tick();
        expectNoWrite("cpu_after");
        checkOutput("cpu_grant_once", {31'd0, cpu_grant_o}, 32'd0);

        $display("[TB] IQ packet with full stall");
        iq_q.push_back(24'hABC123);
        iq_q.push_back(24'h456789);
        iq_q.push_back(24'h000FFF);
        iq_q.push_back(24'hFFF000);
        syncFifos();
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("full_hdr", 32'h00000004);
        tick();
        expectWrite("full_w0", 32'h0ABC0123);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            expectNoWrite($sformatf("full_stall%0d", k));
            checkOutput($sformatf("full_stall_re%0d", k), {31'd0, fifo_re_o}, 32'd0);
            checkOutput($sformatf("full_stall_data%0d", k), data_o, 32'h0ABC0123);
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("full_w1", 32'h04560789);
        tick();
        expectWrite("full_w2", 32'h00000FFF);
        tick();
        expectWrite("full_w3", 32'h0FFF0000);
        checkOutput("full_done_busy", {31'd0, busy_o}, 32'd0);

        $display("[TB] CPU len 0");
        cpu_q.push_back(32'hCAFEF00D);
        syncFifos();
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        tick();
        checkOutput("len0_grant", {31'd0, cpu_grant_o}, 32'd1);
        checkOutput("len0_re_a", {31'd0, cpu_re_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("len0_hdr", 32'h80000000);
        checkOutput("len0_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("len0_re_b", {31'd0, cpu_re_o}, 32'd0);
        tick();
        expectNoWrite("len0_after");
        checkOutput("len0_left", cpu_q.size(), 32'd1);
        cpu_q.delete();
        syncFifos();

        $display("[TB] reset during IQ data");
        for (int k = 0; k < 4; k++) iq_q.push_back(24'h999999);
        syncFifos();
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("rmid_hdr", 32'h00000004);
        tick();
        expectWrite("rmid_w0", 32'h09990999);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rmid_we", {31'd0, we_o}, 32'd0);
        checkOutput("rmid_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rmid_data", data_o, 32'd0);
        @(negedge clk_i);
        reset_n = 1'b1;
        iq_q.delete();
        iq_q.push_back(24'h123456);
        iq_q.push_back(24'h789ABC);
        iq_q.push_back(24'hFEDCBA);
        iq_q.push_back(24'h000001);
        syncFifos();
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        tick();
        checkOutput("rnew_busy", {31'd0, busy_o}, 32'd1);
        expectNoWrite("rnew_grantcyc");
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        expectWrite("rnew_hdr", 32'h00000004);
        tick();
        expectWrite("rnew_w0", 32'h01230456);
        tick();
        expectWrite("rnew_w1", 32'h07890ABC);
        tick();
        expectWrite("rnew_w2", 32'h0FED0CBA);
        tick();
        expectWrite("rnew_w3", 32'h00000001);
        checkOutput("rnew_done_busy", {31'd0, busy_o}, 32'd0);
        tick();
        expectNoWrite("rnew_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
